// File: rtl/wb_pkg.sv
// Shared writeback types for the register-file write path.
// One request is a single register-file write: valid, address, data.
package wb_pkg;

  localparam int RF_ADDR_W = 4;
  localparam int RF_DATA_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

  function automatic wb_req_t mk_req(
    input logic                 v,
    input logic [RF_ADDR_W-1:0] a,
    input logic [RF_DATA_W-1:0] d
  );
    wb_req_t r;
    r.valid = v;
    r.addr  = a;
    r.data  = d;
    return r;
  endfunction

endpackage

// File: rtl/ldr_wb_buffer.sv
// In-order LDR writeback queue with pop, push and cancel-by-address.
// Valid entries always sit compacted at the low indices; slot 0 is the head.
module ldr_wb_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  wb_req_t              push_req,
  input  logic                 pop,
  input  logic                 cancel_en,
  input  logic [RF_ADDR_W-1:0] cancel_addr,
  input  logic [RF_ADDR_W-1:0] chk_addr_a,
  input  logic [RF_ADDR_W-1:0] chk_addr_b,
  output wb_req_t              head,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 pending_a,
  output logic                 pending_b
);

  wb_req_t          q     [DEPTH];
  wb_req_t          q_nxt [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;

  // Survivors are re-packed in order, then the new entry lands at the tail.
  always_comb begin
    int  idx;
    logic keep;
    idx  = 0;
    keep = 1'b0;
    for (int i = 0; i < DEPTH; i++) q_nxt[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      keep = q[i].valid
           && !(pop && i == 0)
           && !(cancel_en && q[i].addr == cancel_addr);
      if (keep) begin
        q_nxt[idx] = q[i];
        idx        = idx + 1;
      end
    end
    if (push && idx < DEPTH) begin
      q_nxt[idx]       = push_req;
      q_nxt[idx].valid = 1'b1;
      idx              = idx + 1;
    end
    cnt_nxt = idx[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
      cnt_q <= cnt_nxt;
    end
  end

  always_comb begin
    pending_a = 1'b0;
    pending_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].valid && q[i].addr == chk_addr_a) pending_a = 1'b1;
      if (q[i].valid && q[i].addr == chk_addr_b) pending_b = 1'b1;
    end
  end

  assign head  = q[0];
  assign count = cnt_q;
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single late register-file write port between ALU and LDR.
// ALU always wins; colliding LDR results queue and drain on idle cycles.
module rf_write_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alu_w_en,
  input  logic [ADDR_W-1:0]            alu_w_addr,
  input  logic [DATA_W-1:0]            alu_w_data,
  input  logic                         ldr_w_en,
  input  logic [ADDR_W-1:0]            ldr_w_addr,
  input  logic [DATA_W-1:0]            ldr_w_data,
  input  logic [ADDR_W-1:0]            chk_addr_a,
  input  logic [ADDR_W-1:0]            chk_addr_b,
  output logic                         rf_w_en,
  output logic [ADDR_W-1:0]            rf_w_addr,
  output logic [DATA_W-1:0]            rf_w_data,
  output logic                         ldr_stall,
  output logic                         pending_a,
  output logic                         pending_b,
  output logic [$clog2(DEPTH+1)-1:0]   buf_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_req_t          alu_req;
  wb_req_t          ldr_req;
  wb_req_t          head;
  wb_req_t          sel;
  logic             pop;
  logic             bypass;
  logic             push;
  logic             cancel_in;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;

  assign alu_req = mk_req(1'b1, alu_w_addr, alu_w_data);
  assign ldr_req = mk_req(1'b1, ldr_w_addr, ldr_w_data);

  // An empty queue can never be full, so bypass needs no stall check.
  always_comb begin
    sel    = '0;
    pop    = 1'b0;
    bypass = 1'b0;
    priority case (1'b1)
      alu_w_en: sel = alu_req;
      !empty: begin
        sel = head;
        pop = 1'b1;
      end
      ldr_w_en: begin
        sel    = ldr_req;
        bypass = 1'b1;
      end
      default: sel = '0;
    endcase
  end

  assign cancel_in = alu_w_en && (ldr_w_addr == alu_w_addr);
  assign push      = ldr_w_en && !full && !bypass && !cancel_in;

  ldr_wb_buffer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_req    (ldr_req),
    .pop         (pop),
    .cancel_en   (alu_w_en),
    .cancel_addr (alu_w_addr),
    .chk_addr_a  (chk_addr_a),
    .chk_addr_b  (chk_addr_b),
    .head        (head),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .pending_a   (pending_a),
    .pending_b   (pending_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_w_en   <= 1'b0;
      rf_w_addr <= '0;
      rf_w_data <= '0;
    end else begin
      rf_w_en   <= sel.valid;
      rf_w_addr <= sel.addr;
      rf_w_data <= sel.data;
    end
  end

  assign ldr_stall = full;
  assign buf_count = count;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed vector bench for rf_write_arbiter.
// Each row's expectations are the outputs one edge after its inputs.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_w_en;
  logic [3:0]  alu_w_addr;
  logic [31:0] alu_w_data;
  logic        ldr_w_en;
  logic [3:0]  ldr_w_addr;
  logic [31:0] ldr_w_data;
  logic [3:0]  chk_addr_a;
  logic [3:0]  chk_addr_b;
  logic        rf_w_en;
  logic [3:0]  rf_w_addr;
  logic [31:0] rf_w_data;
  logic        ldr_stall;
  logic        pending_a;
  logic        pending_b;
  logic [1:0]  buf_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .DEPTH  (2),
    .ADDR_W (4),
    .DATA_W (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_w_en   (alu_w_en),
    .alu_w_addr (alu_w_addr),
    .alu_w_data (alu_w_data),
    .ldr_w_en   (ldr_w_en),
    .ldr_w_addr (ldr_w_addr),
    .ldr_w_data (ldr_w_data),
    .chk_addr_a (chk_addr_a),
    .chk_addr_b (chk_addr_b),
    .rf_w_en    (rf_w_en),
    .rf_w_addr  (rf_w_addr),
    .rf_w_data  (rf_w_data),
    .ldr_stall  (ldr_stall),
    .pending_a  (pending_a),
    .pending_b  (pending_b),
    .buf_count  (buf_count)
  );

  typedef struct {
    logic        ae;
    logic [3:0]  aa;
    logic [31:0] ad;
    logic        le;
    logic [3:0]  la;
    logic [31:0] ld;
    logic [3:0]  ca;
    logic [3:0]  cb;
    logic        ee;
    logic [3:0]  ea;
    logic [31:0] ed;
    logic [1:0]  ec;
    logic        es;
    logic        pa;
    logic        pb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic ae, input logic [3:0] aa, input logic [31:0] ad,
    input logic le, input logic [3:0] la, input logic [31:0] ld,
    input logic [3:0] ca, input logic [3:0] cb,
    input logic ee, input logic [3:0] ea, input logic [31:0] ed,
    input logic [1:0] ec, input logic es,
    input logic pa, input logic pb
  );
    vec_t v;
    v.ae = ae; v.aa = aa; v.ad = ad;
    v.le = le; v.la = la; v.ld = ld;
    v.ca = ca; v.cb = cb;
    v.ee = ee; v.ea = ea; v.ed = ed;
    v.ec = ec; v.es = es; v.pa = pa; v.pb = pb;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ae, input logic [3:0] aa,
                       input logic [31:0] ad, input logic le,
                       input logic [3:0] la, input logic [31:0] ld);
    alu_w_en   = ae;
    alu_w_addr = aa;
    alu_w_data = ad;
    ldr_w_en   = le;
    ldr_w_addr = la;
    ldr_w_data = ld;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    chk_addr_a = 0;
    chk_addr_b = 0;
    rst_n      = 1'b0;

    //        ae aa ad         le la ld           ca cb ee ea ed           ec es pa pb
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,           0, 0, 0, 0, 0,           0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,        1, 3, 32'hDEADBEEF, 0, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h11,   1, 2, 32'h22,      2, 0, 1, 1, 32'h11,      1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,           2, 0, 1, 2, 32'h22,      0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h100,  1, 4, 32'h44,      4, 5, 1, 1, 32'h100,     1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 32'h101,  1, 5, 32'h45,      4, 5, 1, 1, 32'h101,     2, 1, 1, 1));
    vecs.push_back(mk(1, 1, 32'h102,  1, 6, 32'h46,      6, 5, 1, 1, 32'h102,     2, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0,        1, 6, 32'h46,      4, 5, 1, 4, 32'h44,      1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,        1, 6, 32'h46,      6, 5, 1, 5, 32'h45,      1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,           6, 0, 1, 6, 32'h46,      0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h1,    1, 7, 32'hAA,      7, 8, 1, 1, 32'h1,       1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 32'h2,    1, 8, 32'hBB,      7, 8, 1, 1, 32'h2,       2, 1, 1, 1));
    vecs.push_back(mk(1, 7, 32'h55,   0, 0, 0,           7, 8, 1, 7, 32'h55,      1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,           7, 8, 1, 8, 32'hBB,      0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,           7, 8, 0, 0, 0,           0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h3,    1, 2, 32'h77,      2, 9, 1, 1, 32'h3,       1, 0, 1, 0));
    vecs.push_back(mk(1, 9, 32'h99,   1, 9, 32'h90,      2, 9, 1, 9, 32'h99,      1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,           2, 9, 1, 2, 32'h77,      0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,           2, 9, 0, 0, 0,           0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,        1, 15, 32'hF00F,   15, 0, 1, 15, 32'hF00F,  0, 0, 0, 0));

    #12;
    check("rst_en", {31'd0, rf_w_en}, 0);
    check("rst_addr", {28'd0, rf_w_addr}, 0);
    check("rst_data", rf_w_data, 0);
    check("rst_stall", {31'd0, ldr_stall}, 0);
    check("rst_count", {30'd0, buf_count}, 0);
    check("rst_pend", {30'd0, pending_a, pending_b}, 0);

    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].ae, vecs[i].aa, vecs[i].ad,
            vecs[i].le, vecs[i].la, vecs[i].ld);
      chk_addr_a = vecs[i].ca;
      chk_addr_b = vecs[i].cb;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_en", i), {31'd0, rf_w_en}, {31'd0, vecs[i].ee});
      if (vecs[i].ee) begin
        check($sformatf("v%0d_addr", i), {28'd0, rf_w_addr},
              {28'd0, vecs[i].ea});
        check($sformatf("v%0d_data", i), rf_w_data, vecs[i].ed);
      end
      check($sformatf("v%0d_cnt", i), {30'd0, buf_count}, {30'd0, vecs[i].ec});
      check($sformatf("v%0d_stall", i), {31'd0, ldr_stall},
            {31'd0, vecs[i].es});
      check($sformatf("v%0d_pa", i), {31'd0, pending_a}, {31'd0, vecs[i].pa});
      check($sformatf("v%0d_pb", i), {31'd0, pending_b}, {31'd0, vecs[i].pb});
    end

    // Fill the queue with r10/r11, then reset asynchronously mid-cycle.
    @(negedge clk);
    drive(1, 1, 32'h5, 1, 10, 32'hA0);
    chk_addr_a = 10;
    chk_addr_b = 11;
    @(negedge clk);
    drive(1, 1, 32'h6, 1, 11, 32'hB0);
    @(posedge clk);
    #1;
    check("pre_rst_cnt", {30'd0, buf_count}, 2);
    check("pre_rst_pend", {30'd0, pending_a, pending_b}, 3);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_en", {31'd0, rf_w_en}, 0);
    check("arst_addr", {28'd0, rf_w_addr}, 0);
    check("arst_data", rf_w_data, 0);
    check("arst_cnt", {30'd0, buf_count}, 0);
    check("arst_stall", {31'd0, ldr_stall}, 0);
    check("arst_pend", {30'd0, pending_a, pending_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst_en%0d", k), {31'd0, rf_w_en}, 0);
      check($sformatf("post_rst_cnt%0d", k), {30'd0, buf_count}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
